// File: rtl/oci_dct_packer.sv
// rtl/oci_dct_packer.sv - packs 2-bit trace atoms into frames with flush and end-of-trace handling
module oci_dct_packer #(
  parameter int MAX_ATOMS = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending,
  output logic        test_has_ended,
  output logic [7:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ENDED = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ATOMS);

  state_t      state_q, state_d;
  logic [29:0] acc_buf_q, acc_buf_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic [29:0] dct_buffer_q, dct_buffer_d;
  logic [3:0]  dct_count_q, dct_count_d;
  logic        frame_valid_q, frame_valid_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;

  logic        slot_free;
  logic        accept;
  logic        load;

  // Ready is purely a function of registered state (and reset), never of frame_ready
  always_comb begin
    atom_ready = reset_n && (state_q == ST_ACCUM) && (acc_cnt_q < MAX_CNT);
    slot_free  = !frame_valid_q || frame_ready;
    accept     = atom_valid && atom_ready;
  end

  // Next-state: accumulate, move completed or flushed frames to the output register, track stalls
  always_comb begin
    state_d       = state_q;
    acc_buf_d     = acc_buf_q;
    acc_cnt_d     = acc_cnt_q;
    dct_buffer_d  = dct_buffer_q;
    dct_count_d   = dct_count_q;
    frame_valid_d = frame_valid_q;
    stall_cnt_d   = stall_cnt_q;
    load          = 1'b0;

    if (accept) begin
      for (int k = 0; k < 15; k++) begin
        if (acc_cnt_q == 4'(k)) begin
          acc_buf_d[2*k +: 2] = atom;
        end
      end
      acc_cnt_d = acc_cnt_q + 4'd1;
    end

    // A full accumulator always moves out; a partial one only once flushing
    if (slot_free && ((acc_cnt_d == MAX_CNT) ||
                      ((state_q == ST_FLUSH) && (acc_cnt_d != 4'd0)))) begin
      load = 1'b1;
    end

    if (load) begin
      dct_buffer_d  = acc_buf_d;
      dct_count_d   = acc_cnt_d;
      frame_valid_d = 1'b1;
      acc_buf_d     = 30'd0;
      acc_cnt_d     = 4'd0;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    if ((state_q == ST_ACCUM) && atom_valid && !atom_ready && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end

    case (state_q)
      ST_ACCUM: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Done once nothing is left to send and the output slot drains this edge
        if ((acc_cnt_q == 4'd0) && slot_free) begin
          state_d = ST_ENDED;
        end
      end
      ST_ENDED: begin
        state_d = ST_ENDED;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State register with asynchronous clear; any partial or pending frame is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ACCUM;
      acc_buf_q     <= 30'd0;
      acc_cnt_q     <= 4'd0;
      dct_buffer_q  <= 30'd0;
      dct_count_q   <= 4'd0;
      frame_valid_q <= 1'b0;
      stall_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      acc_buf_q     <= acc_buf_d;
      acc_cnt_q     <= acc_cnt_d;
      dct_buffer_q  <= dct_buffer_d;
      dct_count_q   <= dct_count_d;
      frame_valid_q <= frame_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Output drive from registered state
  always_comb begin
    frame_valid    = frame_valid_q;
    dct_buffer     = dct_buffer_q;
    dct_count      = dct_count_q;
    stall_cnt      = stall_cnt_q;
    test_ending    = (state_q != ST_ACCUM);
    test_has_ended = (state_q == ST_ENDED);
  end

endmodule

// File: tb/tb_oci_dct_packer.sv
// tb/tb_oci_dct_packer.sv - directed self-checking bench for oci_dct_packer
module tb_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic [7:0]  stall_cnt;

  int n_checks;
  int n_fail;

  oci_dct_packer #(.MAX_ATOMS(15)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] a);
    atom_valid = 1'b1;
    atom       = a;
    step();
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    atom_valid  = 1'b0;
    atom        = 2'b00;
    flush       = 1'b0;
    frame_ready = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n     = 1'b0;
    atom_valid  = 1'b0;
    atom        = 2'b00;
    flush       = 1'b0;
    frame_ready = 1'b0;
    step();

    // Reset state
    check("rst_atom_ready", 32'(atom_ready), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    check("rst_dct_count", 32'(dct_count), 32'd0);
    check("rst_test_ending", 32'(test_ending), 32'd0);
    check("rst_has_ended", 32'(test_has_ended), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    reset_n = 1'b1;
    step();
    check("post_rst_atom_ready", 32'(atom_ready), 32'd1);

    // Full frame of 2'b01 with consumer always ready
    apply_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 14; i++) offer(2'b01);
    check("t1_no_frame_at_14", 32'(frame_valid), 32'd0);
    offer(2'b01);
    atom_valid = 1'b0;
    check("t1_frame_valid", 32'(frame_valid), 32'd1);
    check("t1_dct_buffer", 32'(dct_buffer), 32'h15555555);
    check("t1_dct_count", 32'(dct_count), 32'hF);
    check("t1_atom_ready", 32'(atom_ready), 32'd1);
    step();
    check("t1_frame_drop", 32'(frame_valid), 32'd0);

    // Back-pressure: two frames queued, stalls counted, then drained back to back
    apply_reset();
    for (int i = 0; i < 15; i++) offer(2'b10);
    for (int i = 0; i < 15; i++) offer(2'b11);
    check("t2_held_valid", 32'(frame_valid), 32'd1);
    check("t2_held_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    check("t2_acc_full_ready", 32'(atom_ready), 32'd0);
    check("t2_no_stall_yet", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) offer(2'b01);
    check("t2_stall_cnt", 32'(stall_cnt), 32'd5);
    check("t2_still_held", 32'(dct_buffer), 32'h2AAAAAAA);
    atom_valid  = 1'b0;
    frame_ready = 1'b1;
    step();
    check("t2_second_valid", 32'(frame_valid), 32'd1);
    check("t2_second_buffer", 32'(dct_buffer), 32'h3FFFFFFF);
    check("t2_second_count", 32'(dct_count), 32'hF);
    check("t2_ready_again", 32'(atom_ready), 32'd1);
    step();
    check("t2_drained", 32'(frame_valid), 32'd0);
    check("t2_stall_kept", 32'(stall_cnt), 32'd5);

    // Partial frame flush
    apply_reset();
    offer(2'b11);
    offer(2'b10);
    offer(2'b01);
    atom_valid = 1'b0;
    flush      = 1'b1;
    step();
    flush = 1'b0;
    check("t3_ending", 32'(test_ending), 32'd1);
    check("t3_not_ended", 32'(test_has_ended), 32'd0);
    check("t3_ready_low", 32'(atom_ready), 32'd0);
    step();
    check("t3_frame_valid", 32'(frame_valid), 32'd1);
    check("t3_dct_buffer", 32'(dct_buffer), 32'h0000001B);
    check("t3_dct_count", 32'(dct_count), 32'd3);
    check("t3_not_ended_yet", 32'(test_has_ended), 32'd0);
    frame_ready = 1'b1;
    step();
    check("t3_has_ended", 32'(test_has_ended), 32'd1);
    check("t3_frame_gone", 32'(frame_valid), 32'd0);
    flush = 1'b1;
    offer(2'b10);
    offer(2'b10);
    atom_valid = 1'b0;
    flush      = 1'b0;
    check("t3_ended_ready", 32'(atom_ready), 32'd0);
    check("t3_ended_no_stall", 32'(stall_cnt), 32'd0);
    check("t3_ended_hold", 32'(test_ending), 32'd1);
    check("t3_ended_no_frame", 32'(frame_valid), 32'd0);

    // Flush with nothing buffered
    apply_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_ending", 32'(test_ending), 32'd1);
    check("t4_not_ended", 32'(test_has_ended), 32'd0);
    step();
    check("t4_has_ended", 32'(test_has_ended), 32'd1);
    check("t4_no_frame", 32'(frame_valid), 32'd0);

    // Atom accepted in the same cycle as flush is kept
    apply_reset();
    atom_valid = 1'b1;
    atom       = 2'b10;
    flush      = 1'b1;
    step();
    atom_valid = 1'b0;
    flush      = 1'b0;
    check("t5_ending", 32'(test_ending), 32'd1);
    step();
    check("t5_frame_valid", 32'(frame_valid), 32'd1);
    check("t5_dct_buffer", 32'(dct_buffer), 32'h00000002);
    check("t5_dct_count", 32'(dct_count), 32'd1);

    // Mid-cycle asynchronous reset discards a partial accumulator
    apply_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 7; i++) offer(2'b11);
    atom_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_ready", 32'(atom_ready), 32'd0);
    check("t6_async_valid", 32'(frame_valid), 32'd0);
    check("t6_async_buffer", 32'(dct_buffer), 32'd0);
    check("t6_async_count", 32'(dct_count), 32'd0);
    check("t6_async_ending", 32'(test_ending), 32'd0);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) offer(2'b01);
    atom_valid = 1'b0;
    check("t6_new_valid", 32'(frame_valid), 32'd1);
    check("t6_new_buffer", 32'(dct_buffer), 32'h15555555);
    check("t6_new_count", 32'(dct_count), 32'hF);

    // Frame completes in the same cycle the previous one is taken
    apply_reset();
    for (int i = 0; i < 15; i++) offer(2'b01);
    for (int i = 0; i < 14; i++) offer(2'b10);
    check("t7_first_held", 32'(dct_buffer), 32'h15555555);
    frame_ready = 1'b1;
    offer(2'b10);
    atom_valid = 1'b0;
    check("t7_valid_stays", 32'(frame_valid), 32'd1);
    check("t7_new_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    check("t7_new_count", 32'(dct_count), 32'hF);
    step();
    check("t7_drained", 32'(frame_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
